// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU data port vs debug/loader port, one access per cycle.
// Build option: define DMEM_ARB_RR_EN for round-robin ties; default is fixed CPU priority with debug starvation relief.
module dmem_arbiter #(
  parameter int WORD       = 64,
  parameter int SIZE       = 1024,
  parameter int STARVE_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [WORD-1:0] cpu_addr,
  input  logic [WORD-1:0] cpu_wdata,
  output logic            cpu_gnt,
  output logic            cpu_stall,
  output logic            cpu_rvalid,
  output logic [WORD-1:0] cpu_rdata,
  output logic            cpu_err,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [WORD-1:0] dbg_addr,
  input  logic [WORD-1:0] dbg_wdata,
  input  logic            dbg_lock,
  output logic            dbg_gnt,
  output logic            dbg_rvalid,
  output logic [WORD-1:0] dbg_rdata,
  output logic            dbg_err,
  output logic            mem_MemRead,
  output logic            mem_MemWrite,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_data,
  input  logic [WORD-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_CPU_PRI, S_DBG_PRI, S_LOCK} state_t;

  state_t          state_q, state_d;
  logic            acc_gnt, acc_we, acc_ok;
  logic [WORD-1:0] acc_addr, acc_wdata;
  logic            rd_vld_p1, owner_dbg_p1, cpu_err_p1, dbg_err_p1;

  function automatic logic addr_ok(input logic [WORD-1:0] a);
    return (a[2:0] == 3'b000) && ((a >> 3) < WORD'(SIZE));
  endfunction

  // Grants are held low while reset is asserted so every output clears at once
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == S_LOCK) begin
        dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        dbg_gnt = (state_q == S_DBG_PRI);
        cpu_gnt = (state_q != S_DBG_PRI);
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  assign cpu_stall = cpu_req & rst_n & ~cpu_gnt;

`ifndef DMEM_ARB_RR_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (dbg_gnt) begin
      starve_q <= '0;
    end else if (dbg_req && (starve_q != CNT_W'(STARVE_MAX))) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    if (state_q == S_LOCK) begin
      if (!dbg_lock) state_d = S_CPU_PRI;
    end else if (dbg_gnt && dbg_lock) begin
      state_d = S_LOCK;
`ifdef DMEM_ARB_RR_EN
    end else if (cpu_req && dbg_req) begin
      state_d = cpu_gnt ? S_DBG_PRI : S_CPU_PRI;
`else
    end else if (dbg_gnt) begin
      state_d = S_CPU_PRI;
    end else if (dbg_req && (starve_q == CNT_W'(STARVE_MAX - 1))) begin
      // Debug has been denied STARVE_MAX times: it wins the next cycle
      state_d = S_DBG_PRI;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_CPU_PRI;
    else        state_q <= state_d;
  end

  always_comb begin
    acc_gnt   = cpu_gnt | dbg_gnt;
    acc_we    = dbg_gnt ? dbg_we    : cpu_we;
    acc_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    acc_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    acc_ok    = acc_gnt && addr_ok(acc_addr);
  end

  assign mem_MemRead  = acc_ok & ~acc_we;
  assign mem_MemWrite = acc_ok &  acc_we;
  assign mem_addr     = acc_ok ? acc_addr  : '0;
  assign mem_data     = acc_ok ? acc_wdata : '0;

  // p1: read ownership and error pulses, one cycle after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1    <= 1'b0;
      owner_dbg_p1 <= 1'b0;
      cpu_err_p1   <= 1'b0;
      dbg_err_p1   <= 1'b0;
    end else begin
      rd_vld_p1  <= mem_MemRead;
      if (mem_MemRead) owner_dbg_p1 <= dbg_gnt;
      cpu_err_p1 <= cpu_gnt & ~acc_ok;
      dbg_err_p1 <= dbg_gnt & ~acc_ok;
    end
  end

  assign cpu_rvalid = rd_vld_p1 & ~owner_dbg_p1;
  assign dbg_rvalid = rd_vld_p1 &  owner_dbg_p1;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  assign cpu_err    = cpu_err_p1;
  assign dbg_err    = dbg_err_p1;

endmodule
